// File: rtl/grf_hazard_pkg.sv
// rtl/grf_hazard_pkg.sv - shared types and encodings for the GRF hazard scoreboard
package grf_hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_slot_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/grf_hazard_operand.sv
// rtl/grf_hazard_operand.sv - stall and forward decision for one D-stage source operand
module grf_hazard_operand
  import grf_hazard_pkg::*;
(
  input  logic [4:0]  addr,
  input  logic [1:0]  tuse,
  input  stage_slot_t slot_e,
  input  stage_slot_t slot_m,
  output logic        stall,
  output logic [1:0]  fwd
);

  logic e_hit;
  logic m_hit;

  always_comb begin
    e_hit = slot_e.valid && (slot_e.dst == addr) && (addr != 5'd0);
    m_hit = slot_m.valid && (slot_m.dst == addr) && (addr != 5'd0);

    stall = (tuse != TUSE_NONE) &&
            ((e_hit && (slot_e.tnew > tuse)) || (m_hit && (slot_m.tnew > tuse)));

    // The youngest writer owns the value; an unready E hit hides any M hit.
    fwd = FWD_GRF;
    if (e_hit) begin
      if (slot_e.tnew == 2'd0) fwd = FWD_E;
    end else if (m_hit && (slot_m.tnew == 2'd0)) begin
      fwd = FWD_M;
    end
  end

endmodule

// File: rtl/grf_hazard_scoreboard_md_busy_counter.sv
// rtl/grf_hazard_scoreboard_md_busy_counter.sv - multiply/divide busy window counter
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (start) begin
      md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign busy = (md_cnt != 4'd0);

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// rtl/grf_hazard_scoreboard.sv - D-stage stall/forward control from E/M writer tracking
module grf_hazard_scoreboard
  import grf_hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iD_Valid,
  input  logic [4:0] iD_Rs,
  input  logic [4:0] iD_Rt,
  input  logic [1:0] iD_TuseRs,
  input  logic [1:0] iD_TuseRt,
  input  logic [4:0] iD_Dst,
  input  logic [1:0] iD_Tnew,
  input  logic       iD_MdStart,
  input  logic       iD_MdIsDiv,
  input  logic       iD_MdUse,
  output logic       oStall,
  output logic [1:0] oFwdRs,
  output logic [1:0] oFwdRt,
  output logic       oMdBusy
);

  stage_slot_t slot_e;
  stage_slot_t slot_m;

  logic       rs_stall;
  logic       rt_stall;
  logic [1:0] rs_fwd;
  logic [1:0] rt_fwd;
  logic       md_busy;
  logic       md_start;

  grf_hazard_operand u_rs (
    .addr   (iD_Rs),
    .tuse   (iD_TuseRs),
    .slot_e (slot_e),
    .slot_m (slot_m),
    .stall  (rs_stall),
    .fwd    (rs_fwd)
  );

  grf_hazard_operand u_rt (
    .addr   (iD_Rt),
    .tuse   (iD_TuseRt),
    .slot_e (slot_e),
    .slot_m (slot_m),
    .stall  (rt_stall),
    .fwd    (rt_fwd)
  );

  // Outputs are forced quiet while reset is held, whatever the stale state says.
  assign oStall  = !reset && iD_Valid && (rs_stall || rt_stall || (iD_MdUse && md_busy));
  assign oFwdRs  = reset ? FWD_GRF : rs_fwd;
  assign oFwdRt  = reset ? FWD_GRF : rt_fwd;
  assign oMdBusy = !reset && md_busy;

  assign md_start = iD_Valid && !oStall && iD_MdStart;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (iD_MdIsDiv),
    .busy   (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_e <= '0;
      slot_m <= '0;
    end else begin
      slot_m <= stage_slot_t'{valid: slot_e.valid, dst: slot_e.dst, tnew: sat_dec(slot_e.tnew)};
      if (iD_Valid && !oStall) begin
        slot_e <= stage_slot_t'{valid: 1'b1, dst: iD_Dst, tnew: iD_Tnew};
      end else begin
        slot_e <= '0;
      end
    end
  end

endmodule
